// File: rtl/vend_pkg.sv
// Shared vend datapath definitions: coin values, one-hot coin codes, dispenser states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Contents: coin value constants, coin bit indices and one-hot codes, dispenser state enum.
package vend_pkg;

    // Coin values in cents
    localparam int NICKEL_VAL  = 5;
    localparam int DIME_VAL    = 10;
    localparam int QUARTER_VAL = 25;

    // Bit positions within coin_out / inv_empty / availability vectors
    localparam int NICKEL_BIT  = 0;
    localparam int DIME_BIT    = 1;
    localparam int QUARTER_BIT = 2;

    // One-hot coin codes
    localparam logic [2:0] COIN_NONE    = 3'b000;
    localparam logic [2:0] COIN_NICKEL  = 3'b001;
    localparam logic [2:0] COIN_DIME    = 3'b010;
    localparam logic [2:0] COIN_QUARTER = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DISPENSE = 3'd1,
        ST_GAP      = 3'd2,
        ST_DONE     = 3'd3,
        ST_FAULT    = 3'd4
    } disp_state_t;

endpackage

// File: rtl/change_dispenser_if.sv
// Request/status bundle between the vend controller and the change dispenser.
// Latency: n/a (wiring only).
// Backpressure: none; load is only honoured while the dispenser is idle (busy low).
// Ports: master drives load/change_in/ack/refill; slave drives coin_out/remaining/busy/done/fault/inv_empty.
interface change_dispenser_if #(
    parameter int AMT_W = 8
);
    logic             load;
    logic [AMT_W-1:0] change_in;
    logic             ack;
    logic             refill;
    logic [2:0]       coin_out;
    logic [AMT_W-1:0] remaining;
    logic             busy;
    logic             done;
    logic             fault;
    logic [2:0]       inv_empty;

    modport master (
        output load, change_in, ack, refill,
        input  coin_out, remaining, busy, done, fault, inv_empty
    );

    modport slave (
        input  load, change_in, ack, refill,
        output coin_out, remaining, busy, done, fault, inv_empty
    );
endinterface

// File: rtl/coin_select.sv
// Greedy coin picker: largest coin not exceeding remaining whose inventory is nonzero.
// Latency: combinational.
// Backpressure: none.
// Ports: remaining (cents), avail (per-coin inventory nonzero) -> pick (one-hot, 0 if none fits), value (cents).
module coin_select
    import vend_pkg::*;
#(
    parameter int AMT_W = 8
) (
    input  logic [AMT_W-1:0] remaining,
    input  logic [2:0]       avail,
    output logic [2:0]       pick,
    output logic [AMT_W-1:0] value
);

    always_comb begin
        pick  = COIN_NONE;
        value = '0;
        if (avail[QUARTER_BIT] && (remaining >= AMT_W'(QUARTER_VAL))) begin
            pick  = COIN_QUARTER;
            value = AMT_W'(QUARTER_VAL);
        end else if (avail[DIME_BIT] && (remaining >= AMT_W'(DIME_VAL))) begin
            pick  = COIN_DIME;
            value = AMT_W'(DIME_VAL);
        end else if (avail[NICKEL_BIT] && (remaining >= AMT_W'(NICKEL_VAL))) begin
            pick  = COIN_NICKEL;
            value = AMT_W'(NICKEL_VAL);
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Pays out a change amount one coin per pulse (greedy quarter/dime/nickel) and tracks inventory.
// Latency: n coins -> coin k after edge 2k-1, done after edge 2n, busy falls at edge 2n+1.
// Backpressure: load ignored unless idle; fault holds until ack or clr.
// Ports: clk_1Hz, clr (async, active-high), bus (slave: load/change_in/ack/refill in; coin_out/remaining/busy/done/fault/inv_empty out).
module change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W  = 8,
    parameter int INV_W  = 4,
    parameter int INIT_Q = 8,
    parameter int INIT_D = 8,
    parameter int INIT_N = 8
) (
    input  logic               clk_1Hz,
    input  logic               clr,
    change_dispenser_if.slave  bus
);

    disp_state_t      state, state_nxt;

    logic [AMT_W-1:0] remaining_q, remaining_nxt;
    logic [2:0]       coin_q, coin_nxt;
    logic             busy_q, busy_nxt;
    logic             done_q, done_nxt;
    logic             fault_q, fault_nxt;
    logic [INV_W-1:0] inv_q, inv_d, inv_n;
    logic [INV_W-1:0] inv_q_nxt, inv_d_nxt, inv_n_nxt;

    logic [2:0]       avail;
    logic [2:0]       pick;
    logic [AMT_W-1:0] pick_val;

    assign avail[QUARTER_BIT] = (inv_q != '0);
    assign avail[DIME_BIT]    = (inv_d != '0);
    assign avail[NICKEL_BIT]  = (inv_n != '0);

    coin_select #(.AMT_W(AMT_W)) u_sel (
        .remaining (remaining_q),
        .avail     (avail),
        .pick      (pick),
        .value     (pick_val)
    );

    always_ff @(posedge clk_1Hz or posedge clr) begin
        if (clr) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining_q;
        coin_nxt      = COIN_NONE;      // pulses last exactly one cycle
        busy_nxt      = busy_q;
        done_nxt      = 1'b0;
        fault_nxt     = fault_q;
        inv_q_nxt     = inv_q;
        inv_d_nxt     = inv_d;
        inv_n_nxt     = inv_n;

        unique case (state)
            ST_IDLE: begin
                if (bus.refill) begin
                    inv_q_nxt = INV_W'(INIT_Q);
                    inv_d_nxt = INV_W'(INIT_D);
                    inv_n_nxt = INV_W'(INIT_N);
                end else if (bus.load) begin
                    if (bus.change_in == '0) begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                    end else if ((bus.change_in % AMT_W'(NICKEL_VAL)) != '0) begin
                        // Not payable in any coin mix; report the owed amount.
                        state_nxt     = ST_FAULT;
                        remaining_nxt = bus.change_in;
                        fault_nxt     = 1'b1;
                        busy_nxt      = 1'b1;
                    end else begin
                        state_nxt     = ST_DISPENSE;
                        remaining_nxt = bus.change_in;
                        busy_nxt      = 1'b1;
                    end
                end
            end

            ST_DISPENSE: begin
                if (pick != COIN_NONE) begin
                    coin_nxt      = pick;
                    remaining_nxt = remaining_q - pick_val;
                    if (pick[QUARTER_BIT]) inv_q_nxt = inv_q - INV_W'(1);
                    if (pick[DIME_BIT])    inv_d_nxt = inv_d - INV_W'(1);
                    if (pick[NICKEL_BIT])  inv_n_nxt = inv_n - INV_W'(1);
                    state_nxt = ST_GAP;
                end else begin
                    state_nxt = ST_FAULT;
                    fault_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                end
            end

            ST_GAP: begin
                if (remaining_q == '0) begin
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
                end else begin
                    state_nxt = ST_DISPENSE;
                end
            end

            ST_DONE: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
            end

            ST_FAULT: begin
                fault_nxt = 1'b1;
                busy_nxt  = 1'b1;
                // Refill is allowed while faulted so the operator can restock before acking.
                if (bus.refill) begin
                    inv_q_nxt = INV_W'(INIT_Q);
                    inv_d_nxt = INV_W'(INIT_D);
                    inv_n_nxt = INV_W'(INIT_N);
                end
                if (bus.ack) begin
                    state_nxt     = ST_IDLE;
                    remaining_nxt = '0;
                    fault_nxt     = 1'b0;
                    busy_nxt      = 1'b0;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_1Hz or posedge clr) begin
        if (clr) begin
            remaining_q <= '0;
            coin_q      <= COIN_NONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            inv_q       <= INV_W'(INIT_Q);
            inv_d       <= INV_W'(INIT_D);
            inv_n       <= INV_W'(INIT_N);
        end else begin
            remaining_q <= remaining_nxt;
            coin_q      <= coin_nxt;
            busy_q      <= busy_nxt;
            done_q      <= done_nxt;
            fault_q     <= fault_nxt;
            inv_q       <= inv_q_nxt;
            inv_d       <= inv_d_nxt;
            inv_n       <= inv_n_nxt;
        end
    end

    assign bus.coin_out  = coin_q;
    assign bus.remaining = remaining_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.fault     = fault_q;

    assign bus.inv_empty[QUARTER_BIT] = (inv_q == '0);
    assign bus.inv_empty[DIME_BIT]    = (inv_d == '0);
    assign bus.inv_empty[NICKEL_BIT]  = (inv_n == '0);

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: payout timing, inventory, fault/ack, refill and clr handling.
// Latency: n/a.
// Backpressure: n/a.
module tb_change_dispenser;
    import vend_pkg::*;

    logic clk_1Hz = 1'b0;
    logic clr;
    int   vecs = 0;
    int   errs = 0;

    always #5 clk_1Hz = ~clk_1Hz;

    change_dispenser_if #(.AMT_W(8)) bus ();

    change_dispenser dut (
        .clk_1Hz (clk_1Hz),
        .clr     (clr),
        .bus     (bus)
    );

    task automatic tick();
        @(posedge clk_1Hz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one load and follow it until done has come and gone, or fault rises (bounded).
    task automatic do_load(input logic [7:0] amt, output int ncoins, output logic [2:0] coins_or,
                           output bit saw_done, output bit saw_fault, output bit saw_busy);
        bus.change_in = amt;
        bus.load      = 1'b1;
        tick();
        bus.load  = 1'b0;
        ncoins    = 0;
        coins_or  = 3'b000;
        saw_done  = 1'b0;
        saw_fault = 1'b0;
        saw_busy  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.coin_out != 3'b000) begin
                ncoins++;
                coins_or = coins_or | bus.coin_out;
            end
            if (bus.busy) saw_busy = 1'b1;
            if (bus.fault) begin
                saw_fault = 1'b1;
                break;
            end
            if (saw_done && !bus.done) break;
            if (bus.done) saw_done = 1'b1;
            tick();
        end
    endtask

    int         nc;
    int         nsum;
    logic [2:0] cor;
    bit         sd, sf, sb;

    initial begin
        clr           = 1'b1;
        bus.load      = 1'b0;
        bus.change_in = '0;
        bus.ack       = 1'b0;
        bus.refill    = 1'b0;
        tick();
        chk("rst_coin",  32'(bus.coin_out), 0);
        chk("rst_rem",   32'(bus.remaining), 0);
        chk("rst_busy",  32'(bus.busy), 0);
        chk("rst_done",  32'(bus.done), 0);
        chk("rst_fault", 32'(bus.fault), 0);
        chk("rst_empty", 32'(bus.inv_empty), 0);
        chk("rst_invq",  32'(dut.inv_q), 8);
        clr = 1'b0;
        tick();

        // 40 cents: quarter, dime, nickel
        bus.change_in = 8'd40;
        bus.load      = 1'b1;
        tick();                                   // edge 0
        bus.load = 1'b0;
        chk("p40_e0_busy", 32'(bus.busy), 1);
        chk("p40_e0_coin", 32'(bus.coin_out), 0);
        tick();                                   // edge 1
        chk("p40_e1_coin", 32'(bus.coin_out), 32'b100);
        chk("p40_e1_rem",  32'(bus.remaining), 15);
        tick();                                   // edge 2
        chk("p40_e2_coin", 32'(bus.coin_out), 0);
        tick();                                   // edge 3
        chk("p40_e3_coin", 32'(bus.coin_out), 32'b010);
        chk("p40_e3_rem",  32'(bus.remaining), 5);
        tick();                                   // edge 4
        chk("p40_e4_coin", 32'(bus.coin_out), 0);
        chk("p40_e4_done", 32'(bus.done), 0);
        tick();                                   // edge 5
        chk("p40_e5_coin", 32'(bus.coin_out), 32'b001);
        chk("p40_e5_rem",  32'(bus.remaining), 0);
        tick();                                   // edge 6
        chk("p40_e6_done", 32'(bus.done), 1);
        chk("p40_e6_busy", 32'(bus.busy), 1);
        tick();                                   // edge 7
        chk("p40_e7_done", 32'(bus.done), 0);
        chk("p40_e7_busy", 32'(bus.busy), 0);
        chk("p40_invq", 32'(dut.inv_q), 7);
        chk("p40_invd", 32'(dut.inv_d), 7);
        chk("p40_invn", 32'(dut.inv_n), 7);

        // Restock, then drain nickels with eight 5-cent payouts
        bus.refill = 1'b1;
        tick();
        bus.refill = 1'b0;
        chk("refill_invn", 32'(dut.inv_n), 8);
        nsum = 0;
        for (int k = 0; k < 8; k++) begin
            do_load(8'd5, nc, cor, sd, sf, sb);
            nsum = nsum + nc;
        end
        chk("drain_coins", 32'(nsum), 8);
        chk("drain_empty", 32'(bus.inv_empty), 32'b001);
        do_load(8'd5, nc, cor, sd, sf, sb);
        chk("nonick_fault", 32'(sf), 1);
        chk("nonick_coins", 32'(nc), 0);
        chk("nonick_rem",   32'(bus.remaining), 5);
        chk("nonick_busy",  32'(bus.busy), 1);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("ack_fault", 32'(bus.fault), 0);
        chk("ack_rem",   32'(bus.remaining), 0);
        chk("ack_busy",  32'(bus.busy), 0);

        // Zero change: done without coins or busy
        do_load(8'd0, nc, cor, sd, sf, sb);
        chk("zero_done",  32'(sd), 1);
        chk("zero_coins", 32'(nc), 0);
        chk("zero_busy",  32'(sb), 0);

        // 12 cents is not a multiple of 5
        do_load(8'd12, nc, cor, sd, sf, sb);
        chk("odd_fault", 32'(sf), 1);
        chk("odd_coins", 32'(nc), 0);
        chk("odd_rem",   32'(bus.remaining), 12);

        // Refill while faulted reloads stock but stays faulted
        bus.refill = 1'b1;
        tick();
        bus.refill = 1'b0;
        chk("frefill_invn",  32'(dut.inv_n), 8);
        chk("frefill_invq",  32'(dut.inv_q), 8);
        chk("frefill_fault", 32'(bus.fault), 1);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("fack_fault", 32'(bus.fault), 0);
        chk("fack_busy",  32'(bus.busy), 0);

        // 35 cents with a second load of 25 while busy, refill during DISPENSE
        bus.change_in = 8'd35;
        bus.load      = 1'b1;
        tick();                                   // edge 0
        bus.change_in = 8'd25;
        tick();                                   // edge 1
        chk("p35_e1_coin", 32'(bus.coin_out), 32'b100);
        chk("p35_e1_rem",  32'(bus.remaining), 10);
        tick();                                   // edge 2
        bus.load   = 1'b0;
        bus.refill = 1'b1;
        tick();                                   // edge 3
        bus.refill = 1'b0;
        chk("p35_e3_coin", 32'(bus.coin_out), 32'b010);
        chk("p35_e3_rem",  32'(bus.remaining), 0);
        chk("p35_invq", 32'(dut.inv_q), 7);
        chk("p35_invd", 32'(dut.inv_d), 7);
        tick();                                   // edge 4
        chk("p35_e4_done", 32'(bus.done), 1);
        tick();                                   // edge 5
        chk("p35_e5_busy", 32'(bus.busy), 0);
        tick();
        chk("p35_after_busy", 32'(bus.busy), 0);
        chk("p35_after_coin", 32'(bus.coin_out), 0);

        // Simultaneous load + refill in IDLE
        bus.change_in = 8'd25;
        bus.load      = 1'b1;
        bus.refill    = 1'b1;
        tick();
        bus.load   = 1'b0;
        bus.refill = 1'b0;
        chk("lr_busy", 32'(bus.busy), 0);
        chk("lr_invq", 32'(dut.inv_q), 8);
        chk("lr_invd", 32'(dut.inv_d), 8);
        tick();
        chk("lr_coin", 32'(bus.coin_out), 0);

        // clr between coin 1 and coin 2 of a 40 payout
        bus.change_in = 8'd40;
        bus.load      = 1'b1;
        tick();                                   // edge 0
        bus.load = 1'b0;
        tick();                                   // edge 1
        chk("clr_e1_coin", 32'(bus.coin_out), 32'b100);
        tick();                                   // edge 2
        clr = 1'b1;
        #1;
        chk("clr_coin",  32'(bus.coin_out), 0);
        chk("clr_rem",   32'(bus.remaining), 0);
        chk("clr_busy",  32'(bus.busy), 0);
        chk("clr_fault", 32'(bus.fault), 0);
        chk("clr_invq",  32'(dut.inv_q), 8);
        chk("clr_state", 32'(dut.state), 32'(ST_IDLE));
        #1;
        clr = 1'b0;
        tick();
        chk("post_clr_busy", 32'(bus.busy), 0);
        chk("post_clr_coin", 32'(bus.coin_out), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
